// File: rtl/interval_timer.sv
// ----------------------------------------------------------------------------
// interval_timer
//
// Programmable interval timer. A one-cycle start_i loads a period P (in ticks)
// and starts a down-counter; when the counter has run out, elapsed_o pulses
// for exactly one clk cycle. In periodic mode the period reloads and the timer
// keeps running. In one-shot mode it returns to IDLE. A one-cycle stop_i aborts
// the count without producing a pulse.
//
// Optional build macro:
//   TIMER_PRESCALE_EN  - when defined, a prescaler divides clk_i by PRESCALE to
//                        form the tick, so one period lasts P*PRESCALE cycles.
//                        When undefined, every clk cycle is a tick and the
//                        prescaler logic is not built.
//
// Parameters:
//   CNT_W          width of the period and the down-counter
//   DEFAULT_TICKS  period used when load_value_i is 0 at start
//   PRESCALE       clk cycles per tick (TIMER_PRESCALE_EN builds only)
//
// Ports:
//   clk_i         system clock, all logic on its rising edge
//   reset_i       synchronous, active-high reset; overrides every other input
//   start_i       load the period and start (or restart) counting
//   stop_i        abort counting; has priority over start_i
//   periodic_i    mode, sampled with start_i: 1 = auto-reload, 0 = one-shot
//   load_value_i  period in ticks, sampled with start_i; 0 selects DEFAULT_TICKS
//   elapsed_o     registered one-clk pulse at each period expiry
//   busy_o        high while the timer is in RUN
//   remaining_o   current down-counter value
// ----------------------------------------------------------------------------
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | not counting; remaining is 0, waiting for start
//   S_RUN  | counting down one step per tick; expires when remaining is 0
// ----------------------------------------------------------------------------
module interval_timer #(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned DEFAULT_TICKS = 500000000,
   parameter int unsigned PRESCALE      = 100
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             periodic_i,
   input  logic [CNT_W-1:0] load_value_i,
   output logic             elapsed_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] remaining_o
);

   localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_TICKS);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q;
   logic             elapsed_q;
   logic [CNT_W-1:0] remaining_q;
   logic [CNT_W-1:0] period_q;
   logic             periodic_q;

   logic [CNT_W-1:0] period_d;
   logic             tick;

   // The zero-to-default substitution happens before the subtraction, so the
   // loaded counter value (period_d - 1) can never underflow.
   assign period_d = (load_value_i == '0) ? DEF_PERIOD : load_value_i;

`ifdef TIMER_PRESCALE_EN
   localparam int unsigned       PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] presc_q;

   assign tick = (presc_q == PS_LAST);

   // Held at zero outside RUN and cleared by start/stop, so a fresh start
   // always waits a full PRESCALE cycles before its first tick.
   always_ff @(posedge clk_i) begin
      if (reset_i || stop_i || start_i || (state_q != S_RUN)) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PS_W'(1);
      end
   end
`else
   assign tick = 1'b1;

   logic unused_prescale;
   assign unused_prescale = (PRESCALE != 0);
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         elapsed_q   <= 1'b0;
         remaining_q <= '0;
         period_q    <= '0;
         periodic_q  <= 1'b0;
      end else begin
         elapsed_q <= 1'b0;
         if (stop_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
         end else if (start_i) begin
            // A start while running is a restart and wins over any expiry
            // that would have fallen in this cycle.
            state_q     <= S_RUN;
            period_q    <= period_d;
            periodic_q  <= periodic_i;
            remaining_q <= period_d - ONE;
         end else if ((state_q == S_RUN) && tick) begin
            if (remaining_q != '0) begin
               remaining_q <= remaining_q - ONE;
            end else begin
               elapsed_q <= 1'b1;
               if (periodic_q) begin
                  remaining_q <= period_q - ONE;
               end else begin
                  state_q     <= S_IDLE;
                  remaining_q <= '0;
               end
            end
         end
      end
   end

   assign elapsed_o   = elapsed_q;
   assign busy_o      = (state_q == S_RUN);
   assign remaining_o = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer. A deadline-based reference model computes the
// expected outputs from the edge at which the active period started; a
// compare process checks every cycle after reset. Directed sequences add
// hand-computed literal expectations.
module tb_interval_timer;

`ifdef TIMER_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif
   localparam int DEF = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        periodic = 1'b0;
   logic [31:0] load_value = '0;
   logic        elapsed;
   logic        busy;
   logic [31:0] remaining;

   int checks = 0;
   int errors = 0;

   interval_timer #(
      .CNT_W        (32),
      .DEFAULT_TICKS(DEF),
      .PRESCALE     (PS)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .stop_i      (stop),
      .periodic_i  (periodic),
      .load_value_i(load_value),
      .elapsed_o   (elapsed),
      .busy_o      (busy),
      .remaining_o (remaining)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   longint cyc = 0;
   longint m_p = 0;
   longint m_ref = 0;
   longint ticks;
   bit     m_run = 0;
   bit     m_per = 0;
   bit     m_valid = 0;
   bit     e_el = 0;
   longint e_rem = 0;
   logic [31:0] e_rem32;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_run = 0; e_el = 0; e_rem = 0; m_p = 0; m_per = 0; m_valid = 1;
      end else if (stop) begin
         m_run = 0; e_el = 0; e_rem = 0;
      end else if (start) begin
         m_p   = (load_value == 0) ? DEF : {32'b0, load_value};
         m_per = periodic;
         m_ref = cyc;
         m_run = 1;
         e_rem = m_p - 1;
         e_el  = 0;
      end else if (m_run) begin
         ticks = (cyc - m_ref) / PS;
         if (ticks >= m_p) begin
            e_el = 1;
            if (m_per) begin
               m_ref = cyc;
               e_rem = m_p - 1;
            end else begin
               m_run = 0;
               e_rem = 0;
            end
         end else begin
            e_el  = 0;
            e_rem = m_p - 1 - ticks;
         end
      end else begin
         e_el = 0;
      end
      e_rem32 = e_rem[31:0];
      #1;
      if (m_valid) begin
         checks++;
         if (elapsed !== e_el) begin
            errors++;
            $display("FAIL model_elapsed cyc=%0d actual=%b required=%b", cyc, elapsed, e_el);
         end
         checks++;
         if (busy !== m_run) begin
            errors++;
            $display("FAIL model_busy cyc=%0d actual=%b required=%b", cyc, busy, m_run);
         end
         checks++;
         if (remaining !== e_rem32) begin
            errors++;
            $display("FAIL model_remaining cyc=%0d actual=%0h required=%0h", cyc, remaining, e_rem32);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // start is sampled at the next rising edge (E0); returns at E0+2.
   task automatic start_op(input logic [31:0] lv, input bit per);
      @(negedge clk);
      start = 1'b1;
      load_value = lv;
      periodic = per;
      step();
      start = 1'b0;
      load_value = $urandom;
      periodic = 1'($urandom_range(0, 1));
   endtask

   task automatic stop_op();
      @(negedge clk);
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   int cnt;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      lit("reset_elapsed", {63'b0, elapsed}, 64'd0);
      lit("reset_busy", {63'b0, busy}, 64'd0);
      lit("reset_remaining", {32'b0, remaining}, 64'd0);

      // one-shot, P=5
      start_op(32'd5, 1'b0);
      lit("os5_rem_e0", {32'b0, remaining}, 64'd4);
      lit("os5_busy_e0", {63'b0, busy}, 64'd1);
      for (int k = 1; k <= 5 * PS; k++) begin
         step();
         lit("os5_elapsed", {63'b0, elapsed}, {63'b0, (k == 5 * PS)});
         lit("os5_busy", {63'b0, busy}, {63'b0, (k < 5 * PS)});
         lit("os5_rem", {32'b0, remaining}, (k < 5 * PS) ? 64'(4 - k / PS) : 64'd0);
      end
      step();
      lit("os5_elapsed_after", {63'b0, elapsed}, 64'd0);

      // periodic, P=3
      start_op(32'd3, 1'b1);
      for (int k = 1; k <= 12 * PS; k++) begin
         step();
         lit("per3_elapsed", {63'b0, elapsed}, {63'b0, (k % (3 * PS) == 0)});
         lit("per3_busy", {63'b0, busy}, 64'd1);
      end
      stop_op();
      lit("per3_stopped", {63'b0, busy}, 64'd0);

      // stop at cycle 4 of a P=10 run
      start_op(32'd10, 1'b0);
      repeat (3) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      lit("stop_busy", {63'b0, busy}, 64'd0);
      lit("stop_rem", {32'b0, remaining}, 64'd0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (elapsed === 1'b1) cnt++;
      end
      lit("stop_no_pulse", 64'(cnt), 64'd0);

      // restart at cycle 3 of a P=4 run
      start_op(32'd4, 1'b0);
      repeat (2) step();
      start = 1'b1;
      load_value = 32'd4;
      periodic = 1'b0;
      step();
      start = 1'b0;
      for (int k = 4; k <= 4 + 4 * PS; k++) begin
         step();
         lit("restart_elapsed", {63'b0, elapsed}, {63'b0, (k == 3 + 4 * PS)});
      end

      // start and stop together, from IDLE and from RUN
      @(negedge clk);
      start = 1'b1; stop = 1'b1; load_value = 32'd6;
      step();
      start = 1'b0; stop = 1'b0;
      lit("startstop_idle_busy", {63'b0, busy}, 64'd0);
      start_op(32'd6, 1'b1);
      step();
      @(negedge clk);
      start = 1'b1; stop = 1'b1; load_value = 32'd2;
      step();
      start = 1'b0; stop = 1'b0;
      lit("startstop_run_busy", {63'b0, busy}, 64'd0);
      lit("startstop_run_rem", {32'b0, remaining}, 64'd0);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (elapsed === 1'b1) cnt++;
      end
      lit("startstop_no_pulse", 64'(cnt), 64'd0);

      // reset mid-RUN
      start_op(32'd10, 1'b1);
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      lit("midreset_elapsed", {63'b0, elapsed}, 64'd0);
      lit("midreset_busy", {63'b0, busy}, 64'd0);
      lit("midreset_rem", {32'b0, remaining}, 64'd0);

      // one-shot P=3 (prescaled build: 3*PS cycles)
      start_op(32'd3, 1'b0);
      for (int k = 1; k <= 3 * PS + 1; k++) begin
         step();
         lit("os3_elapsed", {63'b0, elapsed}, {63'b0, (k == 3 * PS)});
      end

      // load_value 0 selects DEFAULT_TICKS=8
      start_op(32'd0, 1'b0);
      lit("default_rem_e0", {32'b0, remaining}, 64'd7);
      for (int k = 1; k <= 8 * PS + 1; k++) begin
         step();
         lit("default_elapsed", {63'b0, elapsed}, {63'b0, (k == 8 * PS)});
      end

      // all-ones period
      start_op(32'hFFFF_FFFF, 1'b0);
      lit("allones_rem", {32'b0, remaining}, 64'hFFFF_FFFE);
      step();
      stop_op();

      // P=1 periodic: a pulse on every tick
      start_op(32'd1, 1'b1);
      lit("p1per_rem", {32'b0, remaining}, 64'd0);
      for (int k = 1; k <= 6 * PS; k++) begin
         step();
         lit("p1per_elapsed", {63'b0, elapsed}, {63'b0, (k % PS == 0)});
      end
      stop_op();

      // P=1 one-shot
      start_op(32'd1, 1'b0);
      for (int k = 1; k <= PS + 1; k++) begin
         step();
         lit("p1os_elapsed", {63'b0, elapsed}, {63'b0, (k == PS)});
         lit("p1os_busy", {63'b0, busy}, {63'b0, (k < PS)});
      end

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Programmable interval timer that produces the single-cycle `elapsed` pulse consumed by LED/blink and sequencing logic elsewhere in the design.
- It replaces fixed-delay generators with one block that has a start/stop handshake, a loadable period, and one-shot or periodic operation.
- It sits between control logic that issues `start`/`stop` and any consumer that toggles or advances state on `elapsed`.

Parameters:
- CNT_W, 32, width of the period and down-counter in ticks.
- DEFAULT_TICKS, 500000000, period used when `load_value` is 0 at start (5 s at 100 MHz).
- PRESCALE, 100, clk cycles per tick; used only when TIMER_PRESCALE_EN is defined.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request that loads the period and starts counting.
- stop  input  1  one-cycle request that aborts counting without producing `elapsed`.
- periodic  input  1  mode, sampled with `start`: 1 = auto-reload, 0 = one-shot.
- load_value  input  CNT_W  period in ticks, sampled with `start`; 0 selects DEFAULT_TICKS.
- elapsed  output  1  registered one-clk pulse at each period expiry.
- busy  output  1  high while in RUN.
- remaining  output  CNT_W  current down-counter value.

Behaviour:
- Reset: state=IDLE, elapsed=0, busy=0, remaining=0, latched period=0, latched mode=0. Reset overrides every other input.
- States: IDLE and RUN. `busy` is 1 exactly when the state is RUN.
- Input priority each cycle: reset > stop > start > terminal count.
- start (in IDLE or RUN), with stop low:
  - latch period P = (load_value==0) ? DEFAULT_TICKS : load_value;
  - latch `periodic`;
  - remaining <= P-1; state <= RUN; elapsed <= 0.
  - A start in RUN is a restart: it suppresses any expiry due in that same cycle.
- stop (in any state): state <= IDLE, remaining <= 0, elapsed <= 0. A stop has no effect in IDLE other than holding outputs low.
- RUN, on each tick, with no start or stop:
  - remaining != 0: remaining <= remaining-1.
  - remaining == 0: elapsed <= 1. Then:
    - if periodic: remaining <= P-1 and stay in RUN;
    - else: state <= IDLE, busy falls in the same cycle that elapsed rises.
- `elapsed` is 0 in every cycle not described above, so it is never high for two consecutive cycles unless P=1 and periodic.
- Latency without prescale: start sampled at edge E0 puts elapsed high in the cycle after edge EP. Periodic pulses are spaced exactly P clk cycles apart.
- P=1: elapsed follows the cycle after start; periodic mode gives elapsed high continuously.
- Arithmetic: P-1 is computed in CNT_W bits. P is never 0 because the DEFAULT_TICKS substitution happens first. A load_value of all-ones is legal.
- `periodic` and `load_value` are ignored except in the cycle in which `start` is accepted.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - An internal prescaler counts 0..PRESCALE-1 in RUN and issues a tick on wrap.
  - The prescaler clears on start, stop, reset and entry to IDLE.
  - A period lasts P*PRESCALE clk cycles.
  - elapsed is still exactly one clk wide.
  - start/stop act immediately, not on a tick.
- Undefined: the prescaler logic is absent and every clk cycle is a tick.

Test Plan:
- Reset, then start with load_value=5, periodic=0 -> busy high for 5 cycles; elapsed high for exactly 1 cycle, 5 cycles after the start edge; busy falls with it; remaining reads 4,3,2,1,0.
- start with load_value=3, periodic=1, run 12 cycles -> elapsed pulses at cycles 3,6,9,12; busy stays 1.
- start with load_value=10, then stop at cycle 4 -> busy=0, remaining=0, no elapsed in the next 20 cycles.
- start with load_value=4; at cycle 3, start again with load_value=4 -> no pulse at cycle 4; elapsed at cycle 7.
- Same cycle: start and stop asserted -> IDLE, no elapsed. Reset asserted mid-RUN -> all outputs 0 on the next cycle.
- TIMER_PRESCALE_EN with PRESCALE=4, load_value=3, one-shot -> elapsed at cycle 12, one clk wide. Separately, load_value=0 with a reduced DEFAULT_TICKS=8 override -> elapsed at cycle 8.
